// File: rtl/vga_pkg.sv
// vga_pkg: screen geometry, coordinate/colour widths and the FSM state
// encoding shared by vga_plot_arbiter and rect_raster.
package vga_pkg;

    localparam int unsigned XSCREEN  = 160;
    localparam int unsigned YSCREEN  = 120;
    localparam int unsigned X_W      = 8;
    localparam int unsigned Y_W      = 7;
    localparam int unsigned COLOUR_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DRAW = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vga_plot_arbiter_rect_raster.sv
// rect_raster: rasterises one latched rectangle row-major, one pixel per
// cycle, and drives registered pixel outputs for vga_adapter.
//
// Ports:
//   Clock, Reset      clock, asynchronous active-high reset
//   start             one-cycle load strobe: latch load_* and present pixel 0
//   step              high while drawing: advance to the next pixel
//   load_x/y/w/h      origin and size of the rectangle being loaded
//   load_colour       fill colour of the rectangle being loaded
//   empty             load_w or load_h is zero (nothing to draw)
//   last              the pixel currently presented is the final one
//   Plot, X, Y, Colour  registered pixel write to vga_adapter
//
// Build option VGA_PLOT_CLIP_EN: pixel sums are one bit wider and any pixel
// off-screen (x >= XSCREEN or y >= YSCREEN) is suppressed but still consumes
// its cycle. Without it, coordinates wrap at 256 / 128.
module rect_raster
    import vga_pkg::*;
#(
    parameter int unsigned SW_W    = 4
`ifdef VGA_PLOT_CLIP_EN
   ,parameter int unsigned XSCREEN = vga_pkg::XSCREEN,
    parameter int unsigned YSCREEN = vga_pkg::YSCREEN
`endif
)(
    input  logic                Clock,
    input  logic                Reset,
    input  logic                start,
    input  logic                step,
    input  logic [X_W-1:0]      load_x,
    input  logic [Y_W-1:0]      load_y,
    input  logic [SW_W-1:0]     load_w,
    input  logic [SW_W-1:0]     load_h,
    input  logic [COLOUR_W-1:0] load_colour,
    output logic                empty,
    output logic                last,
    output logic                Plot,
    output logic [X_W-1:0]      X,
    output logic [Y_W-1:0]      Y,
    output logic [COLOUR_W-1:0] Colour
);

    logic [X_W-1:0]  base_x;
    logic [Y_W-1:0]  base_y;
    logic [SW_W-1:0] w_q, h_q;
    logic [SW_W-1:0] xc, yc;
    logic [SW_W-1:0] w_m1, h_m1;
    logic [SW_W-1:0] nxc, nyc;
    logic            col_end;

    // Pixel adder operands: origin with zero offset on load, else next pixel
    logic [X_W-1:0]  px_base;
    logic [Y_W-1:0]  py_base;
    logic [SW_W-1:0] off_x, off_y;
    logic [X_W-1:0]  pix_x;
    logic [Y_W-1:0]  pix_y;
    logic            pix_vis;

    assign empty   = (load_w == '0) || (load_h == '0);
    assign w_m1    = w_q - 1'b1;
    assign h_m1    = h_q - 1'b1;
    assign col_end = (xc == w_m1);
    assign last    = col_end && (yc == h_m1);
    assign nxc     = col_end ? '0 : xc + 1'b1;
    assign nyc     = col_end ? yc + 1'b1 : yc;

    assign px_base = start ? load_x : base_x;
    assign py_base = start ? load_y : base_y;
    assign off_x   = start ? '0 : nxc;
    assign off_y   = start ? '0 : nyc;

`ifdef VGA_PLOT_CLIP_EN
    logic [X_W:0] sum_x;
    logic [Y_W:0] sum_y;

    assign sum_x   = {1'b0, px_base} + (X_W+1)'(off_x);
    assign sum_y   = {1'b0, py_base} + (Y_W+1)'(off_y);
    assign pix_vis = (sum_x < (X_W+1)'(XSCREEN)) && (sum_y < (Y_W+1)'(YSCREEN));
    assign pix_x   = sum_x[X_W-1:0];
    assign pix_y   = sum_y[Y_W-1:0];
`else
    assign pix_x   = px_base + X_W'(off_x);
    assign pix_y   = py_base + Y_W'(off_y);
    assign pix_vis = 1'b1;
`endif

    // Outputs are registered one pixel ahead: the load edge presents pixel 0,
    // each drawing edge presents the next one, so xc/yc always name the
    // pixel currently on X/Y and 'last' is valid during that pixel's cycle.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            base_x <= '0;
            base_y <= '0;
            w_q    <= '0;
            h_q    <= '0;
            xc     <= '0;
            yc     <= '0;
            Plot   <= 1'b0;
            X      <= '0;
            Y      <= '0;
            Colour <= '0;
        end else if (start) begin
            base_x <= load_x;
            base_y <= load_y;
            w_q    <= load_w;
            h_q    <= load_h;
            xc     <= '0;
            yc     <= '0;
            Plot   <= !empty && pix_vis;
            if (!empty) begin
                X      <= pix_x;
                Y      <= pix_y;
                Colour <= load_colour;
            end
        end else if (step && !last) begin
            xc   <= nxc;
            yc   <= nyc;
            X    <= pix_x;
            Y    <= pix_y;
            Plot <= pix_vis;
        end else begin
            Plot <= 1'b0;
        end
    end

endmodule

// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter: shares the vga_adapter pixel-write port among NREQ
// rectangle-fill requesters with round-robin arbitration.
//
// Ports:
//   Clock, Reset   clock (CLOCK_50), asynchronous active-high reset
//   Req            per-requester request, held until Ack
//   ReqX/ReqY      per-requester origin, packed X_W / Y_W bits per requester
//   ReqW/ReqH      per-requester size, SW_W bits per requester
//   ReqColour      per-requester fill colour
//   Ack            one-cycle pulse: winner's rectangle latched
//   Done           one-cycle pulse: winner's rectangle finished
//   Busy           high whenever the FSM is not IDLE
//   Plot/X/Y/Colour  pixel write to vga_adapter
//
// Build option VGA_PLOT_CLIP_EN enables off-screen pixel suppression in
// rect_raster; timing is identical either way.
module vga_plot_arbiter
    import vga_pkg::*;
#(
    parameter int unsigned NREQ    = 3,
    parameter int unsigned XSCREEN = vga_pkg::XSCREEN,
    parameter int unsigned YSCREEN = vga_pkg::YSCREEN,
    parameter int unsigned SW_W    = 4
)(
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic [NREQ-1:0]          Req,
    input  logic [NREQ*X_W-1:0]      ReqX,
    input  logic [NREQ*Y_W-1:0]      ReqY,
    input  logic [NREQ*SW_W-1:0]     ReqW,
    input  logic [NREQ*SW_W-1:0]     ReqH,
    input  logic [NREQ*COLOUR_W-1:0] ReqColour,
    output logic [NREQ-1:0]          Ack,
    output logic [NREQ-1:0]          Done,
    output logic                     Busy,
    output logic                     Plot,
    output logic [X_W-1:0]           X,
    output logic [Y_W-1:0]           Y,
    output logic [COLOUR_W-1:0]      Colour
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Reject configurations the packed fields and offset casts cannot hold
    if (NREQ < 2 || NREQ > 8 || XSCREEN > (1 << X_W) || YSCREEN > (1 << Y_W)
        || SW_W > Y_W) begin : g_bad_cfg
        $error("vga_plot_arbiter: unsupported parameter set");
    end

    state_t        state;
    logic [IW-1:0] ptr;
    logic [IW-1:0] winner;
    logic [IW-1:0] pick;

    logic [X_W-1:0]      sel_x;
    logic [Y_W-1:0]      sel_y;
    logic [SW_W-1:0]     sel_w, sel_h;
    logic [COLOUR_W-1:0] sel_colour;
    logic                rect_empty;
    logic                rect_last;

    // Round-robin: first set Req searching upward from ptr+1, wrapping
    always_comb begin
        int unsigned   idx;
        logic [IW-1:0] idx_b;
        logic          found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        idx_b = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx   = (32'(ptr) + i) % NREQ;
            idx_b = IW'(idx);
            if (!found && Req[idx_b]) begin
                pick  = idx_b;
                found = 1'b1;
            end
        end
    end

    // Winner's fields; requester holds them stable through the LOAD cycle
    assign sel_x      = ReqX[winner*X_W +: X_W];
    assign sel_y      = ReqY[winner*Y_W +: Y_W];
    assign sel_w      = ReqW[winner*SW_W +: SW_W];
    assign sel_h      = ReqH[winner*SW_W +: SW_W];
    assign sel_colour = ReqColour[winner*COLOUR_W +: COLOUR_W];

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            ptr    <= IW'(NREQ - 1);
            winner <= '0;
            Ack    <= '0;
            Done   <= '0;
            Busy   <= 1'b0;
        end else begin
            Ack  <= '0;
            Done <= '0;
            case (state)
                ST_IDLE: begin
                    if (|Req) begin
                        winner <= pick;
                        Ack    <= NREQ'(1) << pick;
                        Busy   <= 1'b1;
                        state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rect_empty) begin
                        Done  <= NREQ'(1) << winner;
                        state <= ST_DONE;
                    end else begin
                        state <= ST_DRAW;
                    end
                end
                ST_DRAW: begin
                    if (rect_last) begin
                        Done  <= NREQ'(1) << winner;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    ptr   <= winner;
                    Busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    rect_raster #(
        .SW_W    (SW_W)
`ifdef VGA_PLOT_CLIP_EN
       ,.XSCREEN (XSCREEN),
        .YSCREEN (YSCREEN)
`endif
    ) u_raster (
        .Clock       (Clock),
        .Reset       (Reset),
        .start       (state == ST_LOAD),
        .step        (state == ST_DRAW),
        .load_x      (sel_x),
        .load_y      (sel_y),
        .load_w      (sel_w),
        .load_h      (sel_h),
        .load_colour (sel_colour),
        .empty       (rect_empty),
        .last        (rect_last),
        .Plot        (Plot),
        .X           (X),
        .Y           (Y),
        .Colour      (Colour)
    );

endmodule
